// File: rtl/mc_controller_pkg.sv
// Shared state codes, opcodes and datapath select encodings for the multi-cycle controller.
// Optional feature macro: MC_CONTROLLER_JUMP_EN (adds the JUMP state for JAL/JALR).
package mc_controller_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_WB_ALU   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
`ifdef MC_CONTROLLER_JUMP_EN
    localparam logic [3:0] ST_JUMP     = 4'd10;
`endif
    localparam logic [3:0] ST_HALT     = 4'd11;
    localparam logic [3:0] ST_ERROR    = 4'd12;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    // Same alu_op encoding as the single-cycle decoder.
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles a request goes unanswered and flags the
// cycle on which one more miss would reach TIMEOUT.
module mc_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Asserted in the cycle whose miss would make the count equal TIMEOUT.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle CPU control FSM sharing one memory port between fetch and load/store.
// Optional feature macro: MC_CONTROLLER_JUMP_EN (JAL/JALR via JUMP state, else ERROR).
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       error,
    output logic [3:0] state_dbg
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       is_store;
    logic       in_mem;
    logic       wait_expired;

    assign in_mem = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    // Any state change clears the count, so each memory state starts from zero.
    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state),
        .enable  (in_mem && !mem_ready),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            is_store <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                is_store <= (opcode == OP_STORE);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready)         state_next = ST_DECODE;
                else if (wait_expired) state_next = ST_ERROR;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:           state_next = ST_EXEC_R;
                    OP_ITYPE:           state_next = ST_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = ST_MEM_ADDR;
                    OP_BRANCH:          state_next = ST_BRANCH;
`ifdef MC_CONTROLLER_JUMP_EN
                    OP_JAL, OP_JALR:    state_next = ST_JUMP;
`else
                    OP_JAL, OP_JALR:    state_next = ST_ERROR;
`endif
                    OP_HALT:            state_next = ST_HALT;
                    default:            state_next = ST_ERROR;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_next = ST_WB_ALU;
            ST_MEM_ADDR: state_next = is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)         state_next = ST_WB_MEM;
                else if (wait_expired) state_next = ST_ERROR;
            end
            ST_MEM_WR: begin
                if (mem_ready)         state_next = ST_FETCH;
                else if (wait_expired) state_next = ST_ERROR;
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH: state_next = ST_FETCH;
`ifdef MC_CONTROLLER_JUMP_EN
            ST_JUMP:  state_next = ST_FETCH;
`endif
            ST_HALT:  state_next = ST_HALT;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_ERROR;
        endcase
    end

    // FETCH strobes are gated by reset so outputs read as idle while it is held.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_B_FOUR;
        alu_op        = ALU_OP_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req  = !reset;
                ir_write = !reset && mem_ready;
                pc_write = !reset && mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_RS2;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_WB_ALU: reg_write = 1'b1;
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALU_B_RS2;
                alu_op        = ALU_OP_BRANCH;
                pc_write_cond = 1'b1;
            end
`ifdef MC_CONTROLLER_JUMP_EN
            ST_JUMP: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign halted    = (state == ST_HALT);
    assign error     = (state == ST_ERROR);
    assign state_dbg = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected output vectors in a queue,
// masked to the fields defined for each state. Honors MC_CONTROLLER_JUMP_EN.
module tb_mc_controller;
    import mc_controller_pkg::*;

    localparam int W = 17;

    // Strobe field {mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write}
    localparam logic [5:0] S_REQ = 6'b100000;
    localparam logic [5:0] S_WE  = 6'b010000;
    localparam logic [5:0] S_IRW = 6'b001000;
    localparam logic [5:0] S_PCW = 6'b000100;
    localparam logic [5:0] S_PCC = 6'b000010;
    localparam logic [5:0] S_RW  = 6'b000001;

    // Select field {iord, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0]}
    localparam logic [W-1:0] M_ALL  = {W{1'b1}};
    localparam logic [W-1:0] M_STR  = {4'hF, 6'h3F, 7'h00};
    localparam logic [W-1:0] M_IORD = 17'h00040;
    localparam logic [W-1:0] M_M2R  = 17'h00020;
    localparam logic [W-1:0] M_ALU  = 17'h0001F;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic       alu_src_a, reg_write, mem_to_reg, halted, error;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    logic         rdy_q[$];

    mc_controller #(.TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .halted        (halted),
        .error         (error),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] v(logic [3:0] st, logic [5:0] str, logic [6:0] sel);
        return {st, str, sel};
    endfunction

    function automatic logic [W-1:0] observe();
        return {state_dbg, mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
                iord, mem_to_reg, alu_src_a, alu_src_b, alu_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic apply_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input logic ready, input logic [W-1:0] exp, input logic [W-1:0] msk);
        rdy_q.push_back(ready);
        exp_q.push_back(exp);
        msk_q.push_back(msk);
    endtask

    // Starts just after a rising edge; ends on the falling edge of the last cycle.
    task automatic run(input string tag);
        int cyc_n = 1;
        logic [W-1:0] e, m;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            check($sformatf("%s_c%0d", tag, cyc_n), 32'(observe() & m), 32'(e & m));
            cyc_n++;
            if (exp_q.size() > 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic push_fetch_hit();
        push(1'b1, v(ST_FETCH, S_REQ | S_IRW | S_PCW, 7'b0000100), M_STR | M_IORD | M_ALU);
    endtask

    task automatic push_decode();
        push(1'b1, v(ST_DECODE, 6'b0, 7'b0), M_STR);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = OP_RTYPE;

        // Reset state: mem_ready high must not leak into FETCH strobes.
        @(negedge clk);
        check("rst_outputs", 32'(observe()), 32'(v(ST_FETCH, 6'b0, 7'b0000100)));
        check("rst_flags", {30'b0, halted, error}, 32'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("first_req", {31'b0, mem_req}, 32'd1);

        // R-type, zero wait
        apply_reset();
        opcode = OP_RTYPE;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_EXEC_R, 6'b0, 7'b0010010), M_STR | M_ALU);
        push(1'b1, v(ST_WB_ALU, S_RW, 7'b0), M_STR | M_M2R);
        push_fetch_hit();
        run("rtype");

        // I-type
        apply_reset();
        opcode = OP_ITYPE;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_EXEC_I, 6'b0, 7'b0011010), M_STR | M_ALU);
        push(1'b1, v(ST_WB_ALU, S_RW, 7'b0), M_STR | M_M2R);
        push_fetch_hit();
        run("itype");

        // Load, three wait cycles in MEM_RD
        apply_reset();
        opcode = OP_LOAD;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_MEM_ADDR, 6'b0, 7'b0011000), M_STR | M_ALU);
        for (int i = 0; i < 3; i++)
            push(1'b0, v(ST_MEM_RD, S_REQ, 7'b1000000), M_STR | M_IORD);
        push(1'b1, v(ST_MEM_RD, S_REQ, 7'b1000000), M_STR | M_IORD);
        push(1'b1, v(ST_WB_MEM, S_RW, 7'b0100000), M_STR | M_M2R);
        push_fetch_hit();
        run("load");

        // Store, zero wait
        apply_reset();
        opcode = OP_STORE;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_MEM_ADDR, 6'b0, 7'b0011000), M_STR | M_ALU);
        push(1'b1, v(ST_MEM_WR, S_REQ | S_WE, 7'b1000000), M_STR | M_IORD);
        push_fetch_hit();
        run("store");

        // Branch
        apply_reset();
        opcode = OP_BRANCH;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_BRANCH, S_PCC, 7'b0010001), M_STR | M_ALU);
        push_fetch_hit();
        run("branch");

        // Halt: held with mem_ready high, no further requests
        apply_reset();
        opcode = OP_HALT;
        push_fetch_hit();
        push_decode();
        for (int i = 0; i < 3; i++)
            push(1'b1, v(ST_HALT, 6'b0, 7'b0), M_STR);
        run("halt");
        check("halt_flags", {30'b0, halted, error}, 32'b10);

        // Illegal opcode
        apply_reset();
        opcode = 7'b0000000;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_ERROR, 6'b0, 7'b0), M_STR);
        push(1'b1, v(ST_ERROR, 6'b0, 7'b0), M_STR);
        run("illegal");
        check("illegal_flags", {30'b0, halted, error}, 32'b01);

        // JAL / JALR
        for (int j = 0; j < 2; j++) begin
            apply_reset();
            opcode = (j == 0) ? OP_JAL : OP_JALR;
            push_fetch_hit();
            push_decode();
`ifdef MC_CONTROLLER_JUMP_EN
            push(1'b1, v(ST_JUMP, S_RW | S_PCW, 7'b0), M_STR);
            push_fetch_hit();
            run($sformatf("jump%0d", j));
            check($sformatf("jump%0d_err", j), {31'b0, error}, 32'd0);
`else
            push(1'b1, v(ST_ERROR, 6'b0, 7'b0), M_STR);
            run($sformatf("jump%0d", j));
            check($sformatf("jump%0d_err", j), {31'b0, error}, 32'd1);
`endif
        end

        // Timeout in FETCH: 64 missed cycles
        apply_reset();
        opcode = OP_RTYPE;
        for (int i = 0; i < 64; i++)
            push(1'b0, v(ST_FETCH, S_REQ, 7'b0000100), M_STR | M_IORD);
        push(1'b0, v(ST_ERROR, 6'b0, 7'b0), M_STR);
        run("tmo");
        check("tmo_error", {31'b0, error}, 32'd1);

        // mem_ready on cycle 64 wins over the timeout
        apply_reset();
        for (int i = 0; i < 63; i++)
            push(1'b0, v(ST_FETCH, S_REQ, 7'b0000100), M_STR | M_IORD);
        push_fetch_hit();
        push_decode();
        run("tmo_edge");
        check("tmo_edge_error", {31'b0, error}, 32'd0);

        // Reset in the middle of a stalled store
        apply_reset();
        opcode = OP_STORE;
        push_fetch_hit();
        push_decode();
        push(1'b1, v(ST_MEM_ADDR, 6'b0, 7'b0011000), M_STR | M_ALU);
        push(1'b0, v(ST_MEM_WR, S_REQ | S_WE, 7'b1000000), M_STR | M_IORD);
        run("rst_mid");
        reset = 1'b1;
        #1;
        check("rst_mid_we", {31'b0, mem_we}, 32'd0);
        check("rst_mid_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_state", {28'b0, state_dbg}, {28'b0, ST_FETCH});
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_refetch", 32'(observe() & (M_STR | M_IORD)),
              32'(v(ST_FETCH, S_REQ, 7'b0000100) & (M_STR | M_IORD)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
